ram_bus_arbiter: RTL and testbench

- Shares the single data-RAM port between two bus masters: M0 (CPU_RV32I data bus) and M1 (DMA/debug loader).
- Sits between the masters and RAM inside MCU.
- Registered-owner FSM with round-robin fairness, a per-master lock for atomic multi-access sequences, and a hold limit that stops one master starving the other.
- RAM is assumed single-cycle: write at the clock edge, combinational read.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/ram_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types for the data-RAM bus arbiter: owner FSM states and the
// per-master access request bundle.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } owner_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        funct3;
  } bus_req_t;

endpackage

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for the single-cycle data RAM: registered owner FSM with
// round-robin hand-over, per-master lock and a hold limit against starvation.
module ram_bus_arbiter #(
  parameter int ADDR_W   = bus_pkg::ADDR_W,
  parameter int DATA_W   = bus_pkg::DATA_W,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_funct3,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [2:0]        ram_funct3,
  input  logic [DATA_W-1:0] ram_rdata
);

  import bus_pkg::*;

  localparam int               CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  owner_state_e     r_state;
  owner_state_e     w_nextState;
  owner_state_e     w_otherState;
  logic             r_lastOwner;
  logic [CNT_W-1:0] r_holdCnt;
  logic [CNT_W-1:0] w_nextHoldCnt;

  bus_req_t w_m0Req;
  bus_req_t w_m1Req;
  bus_req_t w_ownerReq;
  bus_req_t w_ramReq;
  bus_req_t r_heldReq;

  logic w_ownerLock;
  logic w_ownerActive;
  logic w_otherReq;
  logic w_granted;

  logic              r_m0Rvalid;
  logic              r_m1Rvalid;
  logic [DATA_W-1:0] r_m0Rdata;
  logic [DATA_W-1:0] r_m1Rdata;

  assign w_m0Req = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, funct3: m0_funct3};
  assign w_m1Req = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, funct3: m1_funct3};

  always_comb begin
    w_ownerReq    = r_heldReq;
    w_ownerLock   = 1'b0;
    w_ownerActive = 1'b0;
    w_otherReq    = 1'b0;
    w_otherState  = IDLE;
    unique case (r_state)
      OWN0: begin
        w_ownerReq    = w_m0Req;
        w_ownerLock   = m0_lock;
        w_ownerActive = m0_req;
        w_otherReq    = m1_req;
        w_otherState  = OWN1;
      end
      OWN1: begin
        w_ownerReq    = w_m1Req;
        w_ownerLock   = m1_lock;
        w_ownerActive = m1_req;
        w_otherReq    = m0_req;
        w_otherState  = OWN0;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = (r_state == OWN0) & m0_req;
  assign m1_gnt    = (r_state == OWN1) & m1_req;
  assign w_granted = m0_gnt | m1_gnt;

  // Without a grant the RAM keeps seeing the last granted access.
  assign w_ramReq   = w_granted ? w_ownerReq : r_heldReq;
  assign ram_we     = w_ramReq.we & w_granted;
  assign ram_addr   = w_ramReq.addr;
  assign ram_wdata  = w_ramReq.wdata;
  assign ram_funct3 = w_ramReq.funct3;

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (m0_req && m1_req)
          w_nextState = r_lastOwner ? OWN0 : OWN1;
        else if (m0_req)
          w_nextState = OWN0;
        else if (m1_req)
          w_nextState = OWN1;
      end
      OWN0, OWN1: begin
        if (w_otherReq && w_granted && (r_holdCnt == HOLD_LAST))
          w_nextState = w_otherState;
        else if (w_ownerLock && w_ownerActive)
          w_nextState = r_state;
        else if (w_otherReq)
          w_nextState = w_otherState;
        else if (w_ownerActive)
          w_nextState = r_state;
        else
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The hold count only measures time the other master has been kept waiting.
  always_comb begin
    w_nextHoldCnt = r_holdCnt;
    if ((w_nextState != r_state) || !w_otherReq)
      w_nextHoldCnt = '0;
    else if (w_granted && (r_holdCnt != HOLD_LAST))
      w_nextHoldCnt = r_holdCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_lastOwner <= 1'b1;
      r_holdCnt   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_holdCnt <= w_nextHoldCnt;
      if ((r_state != IDLE) && (w_nextState != r_state))
        r_lastOwner <= (r_state == OWN1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_heldReq  <= '0;
      r_m0Rvalid <= 1'b0;
      r_m1Rvalid <= 1'b0;
      r_m0Rdata  <= '0;
      r_m1Rdata  <= '0;
    end else begin
      r_m0Rvalid <= m0_gnt & ~m0_we;
      r_m1Rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we)
        r_m0Rdata <= ram_rdata;
      if (m1_gnt && !m1_we)
        r_m1Rdata <= ram_rdata;
      if (w_granted)
        r_heldReq <= w_ownerReq;
    end
  end

  assign m0_rvalid = r_m0Rvalid;
  assign m1_rvalid = r_m1Rvalid;
  assign m0_rdata  = r_m0Rdata;
  assign m1_rdata  = r_m1Rdata;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter (MAX_HOLD=4): vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_ram_bus_arbiter;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [2];
  logic        lock [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [2:0]  funct3 [2];
  logic        m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
  logic [31:0] m0Rdata, m1Rdata;
  logic        ramWe;
  logic [31:0] ramAddr, ramWdata, ramRdata;
  logic [2:0]  ramFunct3;

  int total;
  int bad;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_funct3(funct3[0]),
    .m0_gnt(m0Gnt), .m0_rvalid(m0Rvalid), .m0_rdata(m0Rdata),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_funct3(funct3[1]),
    .m1_gnt(m1Gnt), .m1_rvalid(m1Rvalid), .m1_rdata(m1Rdata),
    .ram_we(ramWe), .ram_addr(ramAddr), .ram_wdata(ramWdata),
    .ram_funct3(ramFunct3), .ram_rdata(ramRdata)
  );

  // Behavioural RAM: 16 words, written at the edge, read combinationally.
  logic [31:0] ramMem [16];
  logic        pokeEn;
  logic [3:0]  pokeIdx;
  logic [31:0] pokeData;

  assign ramRdata = ramMem[ramAddr[5:2]];

  always @(posedge clk) begin
    if (pokeEn)
      ramMem[pokeIdx] <= pokeData;
    else if (ramWe)
      ramMem[ramAddr[5:2]] <= ramWdata;
  end

  // Reference model state: owner -1 means nobody owns the port.
  int          mOwner, mLast, mStreak;
  logic [31:0] mHeldAddr, mHeldWdata;
  logic [2:0]  mHeldF3;
  logic        mRv [2];
  logic [31:0] mRd [2];
  logic [31:0] modelMem [16];

  typedef struct {
    logic r0, l0, w0; logic [31:0] a0;
    logic r1, l1, w1; logic [31:0] a1;
    logic eg0, eg1, ewe; logic [31:0] eaddr; logic erv0, erv1;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] patWord(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic l0, input logic w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic l1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    req[0] = r0; lock[0] = l0; we[0] = w0; addr[0] = a0; wdata[0] = d0; funct3[0] = 3'b010;
    req[1] = r1; lock[1] = l1; we[1] = w1; addr[1] = a1; wdata[1] = d1; funct3[1] = 3'b010;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic resetAndFill();
    reset = 1'b0;
    idleInputs();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      pokeIdx     = 4'(i);
      pokeData    = patWord(i);
      modelMem[i] = patWord(i);
      pokeEn      = 1'b1;
      @(negedge clk);
    end
    pokeEn = 1'b0;
    reset  = 1'b1;
  endtask

  task automatic modelReset();
    mOwner = -1; mLast = 1; mStreak = 0;
    mHeldAddr = '0; mHeldWdata = '0; mHeldF3 = '0;
    for (int i = 0; i < 2; i++) begin
      mRv[i] = 1'b0;
      mRd[i] = '0;
    end
  endtask

  // One clock of the arbitration rules, using the inputs present at the edge.
  task automatic modelStep();
    int   o, nxt, other;
    logic granted;
    o = mOwner;
    granted = (o >= 0) && req[o];
    mRv[0] = 1'b0;
    mRv[1] = 1'b0;
    if (granted) begin
      mHeldAddr = addr[o]; mHeldWdata = wdata[o]; mHeldF3 = funct3[o];
      if (we[o])
        modelMem[addr[o][5:2]] = wdata[o];
      else begin
        mRv[o] = 1'b1;
        mRd[o] = modelMem[addr[o][5:2]];
      end
    end
    if (o < 0) begin
      if (req[0] && req[1]) nxt = 1 - mLast;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
    end else begin
      other = 1 - o;
      if (req[other] && granted && (mStreak + 1 >= MAXH)) nxt = other;
      else if (lock[o] && req[o])                          nxt = o;
      else if (req[other])                                 nxt = other;
      else if (req[o])                                     nxt = o;
      else                                                 nxt = -1;
    end
    if (o >= 0 && nxt != o) begin
      mLast   = o;
      mStreak = 0;
    end else if (o < 0 || !req[1 - o])
      mStreak = 0;
    else if (granted)
      mStreak = (mStreak + 1 < MAXH) ? mStreak + 1 : MAXH - 1;
    mOwner = nxt;
  endtask

  task automatic randomizeMaster(input int i);
    req[i]    = ($urandom_range(0, 99) < 75);
    lock[i]   = 1'($urandom_range(0, 1));
    we[i]     = 1'($urandom_range(0, 1));
    addr[i]   = 32'($urandom_range(0, 15)) << 2;
    wdata[i]  = $urandom;
    funct3[i] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int   m0Count, firstM1, bothCnt;
    logic expG [2];
    logic lastG [2];
    logic anyG;

    total = 0; bad = 0; pokeEn = 1'b0; pokeIdx = '0; pokeData = '0;
    reset = 1'b0;
    idleInputs();

    // Single read after reset: grant next cycle, data the cycle after.
    resetAndFill();
    #1 checkOutput("rst.gnt0", m0Gnt, 0);
    checkOutput("rst.rvalid0", m0Rvalid, 0);
    checkOutput("rst.ramAddr", ramAddr, 0);
    checkOutput("rst.ramWe", ramWe, 0);
    applyStimulus(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("t1.idleGnt", m0Gnt, 0);
    @(negedge clk); #1;
    checkOutput("t1.gnt0", m0Gnt, 1);
    checkOutput("t1.ramAddr", ramAddr, 32'h10);
    checkOutput("t1.earlyRvalid", m0Rvalid, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("t1.rvalid0", m0Rvalid, 1);
    checkOutput("t1.rdata0", m0Rdata, 32'hDEADBEEF);
    checkOutput("t1.gnt1", m1Gnt, 0);
    checkOutput("t1.rvalid1", m1Rvalid, 0);
    checkOutput("t1.rdata1", m1Rdata, 0);
    @(negedge clk); #1 checkOutput("t1.rvalidDrop", m0Rvalid, 0);

    // Table: round-robin, then a 3-write locked burst, then release to idle.
    vecs[0]  = '{1,0,0,32'h04, 1,0,0,32'h08, 0,0,0,32'h00, 0,0};
    vecs[1]  = '{1,0,0,32'h04, 1,0,0,32'h08, 1,0,0,32'h04, 0,0};
    vecs[2]  = '{1,0,0,32'h04, 1,0,0,32'h08, 0,1,0,32'h08, 1,0};
    vecs[3]  = '{1,0,0,32'h04, 1,0,0,32'h08, 1,0,0,32'h04, 0,1};
    vecs[4]  = '{1,1,1,32'h30, 1,0,0,32'h08, 0,1,0,32'h08, 1,0};
    vecs[5]  = '{1,1,1,32'h30, 1,0,0,32'h08, 1,0,1,32'h30, 0,1};
    vecs[6]  = '{1,1,1,32'h34, 1,0,0,32'h08, 1,0,1,32'h34, 0,0};
    vecs[7]  = '{1,0,1,32'h38, 1,0,0,32'h08, 1,0,1,32'h38, 0,0};
    vecs[8]  = '{0,0,0,32'h00, 1,0,0,32'h08, 0,1,0,32'h08, 0,0};
    vecs[9]  = '{0,0,0,32'h00, 0,0,0,32'h00, 0,0,0,32'h08, 0,1};
    vecs[10] = '{0,0,0,32'h00, 0,0,0,32'h00, 0,0,0,32'h08, 0,0};
    resetAndFill();
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].r0, vecs[v].l0, vecs[v].w0, vecs[v].a0, 32'hC0DE_0000 | vecs[v].a0,
                    vecs[v].r1, vecs[v].l1, vecs[v].w1, vecs[v].a1, 32'hBEEF_0000 | vecs[v].a1);
      #1;
      checkOutput($sformatf("vec%0d.gnt0", v), m0Gnt, vecs[v].eg0);
      checkOutput($sformatf("vec%0d.gnt1", v), m1Gnt, vecs[v].eg1);
      checkOutput($sformatf("vec%0d.ramWe", v), ramWe, vecs[v].ewe);
      checkOutput($sformatf("vec%0d.ramAddr", v), ramAddr, vecs[v].eaddr);
      checkOutput($sformatf("vec%0d.rvalid0", v), m0Rvalid, vecs[v].erv0);
      checkOutput($sformatf("vec%0d.rvalid1", v), m1Rvalid, vecs[v].erv1);
      @(negedge clk);
    end

    // Lock stuck high: hold limit forces hand-over after MAXH grants.
    resetAndFill();
    applyStimulus(1, 1, 0, 32'h00, 0, 1, 0, 0, 32'h0C, 0);
    m0Count = 0; firstM1 = -1; bothCnt = 0;
    for (int c = 0; c < 12 && firstM1 < 0; c++) begin
      #1;
      if (m0Gnt && m1Gnt) bothCnt++;
      if (m1Gnt) firstM1 = c;
      else if (m0Gnt) m0Count++;
      @(negedge clk);
    end
    checkOutput("hold.m0Grants", 32'(m0Count), MAXH);
    checkOutput("hold.firstM1Cycle", 32'(firstM1), MAXH + 1);
    checkOutput("hold.bothGnt", 32'(bothCnt), 0);

    // M1 writes, then M0 reads the same word back.
    resetAndFill();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h20, 32'hA5A5A5A5);
    #1 checkOutput("wr.idleWe", ramWe, 0);
    @(negedge clk); #1;
    checkOutput("wr.gnt1", m1Gnt, 1);
    checkOutput("wr.ramWe", ramWe, 1);
    checkOutput("wr.ramWdata", ramWdata, 32'hA5A5A5A5);
    @(negedge clk);
    applyStimulus(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("wr.noGntWe", ramWe, 0);
    @(negedge clk); #1;
    checkOutput("rd.gnt0", m0Gnt, 1);
    checkOutput("rd.ramWe", ramWe, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("rd.rvalid0", m0Rvalid, 1);
    checkOutput("rd.rdata0", m0Rdata, 32'hA5A5A5A5);
    checkOutput("rd.rvalid1", m1Rvalid, 0);

    // Reset between a granted read and its rvalid edge.
    resetAndFill();
    applyStimulus(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1 checkOutput("mid.gnt0", m0Gnt, 1);
    reset = 1'b0;
    #1;
    checkOutput("mid.rvalid0", m0Rvalid, 0);
    checkOutput("mid.gntAfterRst", m0Gnt, 0);
    checkOutput("mid.ramWe", ramWe, 0);
    checkOutput("mid.ramAddr", ramAddr, 0);
    applyStimulus(1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h14, 0);
    @(negedge clk); #1 checkOutput("mid.rvalidHeld", m0Rvalid, 0);
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("mid.firstGnt0", m0Gnt, 1);
    checkOutput("mid.firstGnt1", m1Gnt, 0);

    // Random traffic against the reference model, with one reset midway.
    resetAndFill();
    modelReset();
    lastG[0] = 1'b0;
    lastG[1] = 1'b0;
    for (int c = 0; c < 1600; c++) begin
      if (c == 800) begin
        resetAndFill();
        modelReset();
        lastG[0] = 1'b0;
        lastG[1] = 1'b0;
      end
      for (int i = 0; i < 2; i++)
        if (!(req[i] && !lastG[i])) randomizeMaster(i);
      #1;
      expG[0] = (mOwner == 0) && req[0];
      expG[1] = (mOwner == 1) && req[1];
      anyG = expG[0] || expG[1];
      checkOutput($sformatf("rand%0d.gnt0", c), m0Gnt, expG[0]);
      checkOutput($sformatf("rand%0d.gnt1", c), m1Gnt, expG[1]);
      checkOutput($sformatf("rand%0d.ramWe", c), ramWe, anyG && we[mOwner]);
      checkOutput($sformatf("rand%0d.ramAddr", c), ramAddr, anyG ? addr[mOwner] : mHeldAddr);
      checkOutput($sformatf("rand%0d.ramWdata", c), ramWdata, anyG ? wdata[mOwner] : mHeldWdata);
      checkOutput($sformatf("rand%0d.ramF3", c), ramFunct3, anyG ? funct3[mOwner] : mHeldF3);
      checkOutput($sformatf("rand%0d.rvalid0", c), m0Rvalid, mRv[0]);
      checkOutput($sformatf("rand%0d.rvalid1", c), m1Rvalid, mRv[1]);
      checkOutput($sformatf("rand%0d.rdata0", c), m0Rdata, mRd[0]);
      checkOutput($sformatf("rand%0d.rdata1", c), m1Rdata, mRd[1]);
      lastG[0] = expG[0];
      lastG[1] = expG[1];
      modelStep();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
